// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, source count,
// vector width, confINT field offsets and the fixed-priority encoder.
package int_ctrl_pkg;

  localparam int NUM_SRC  = 8;
  localparam int VEC_W    = 3;
  localparam int EN_LSB   = 0;
  localparam int MODE_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest-index set bit wins; returns 0 when nothing is set.
  function automatic logic [VEC_W-1:0] prio_enc(input logic [NUM_SRC-1:0] p);
    prio_enc = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) prio_enc = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/int_src_cell.sv
// One interrupt source: optional 2-flop synchronizer (INT_CTRL_SYNC_EN),
// edge-history register and the pending bit for edge or level mode.
module int_src_cell (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic en,
  input  logic mode,
  input  logic clr,
  output logic pend
);

  logic src_s;
  logic src_q;
  logic rise;

`ifdef INT_CTRL_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Two-flop synchronizer for an asynchronous source
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
    end
  end

  assign src_s = sync_p1;
`else
  assign src_s = src;
`endif

  assign rise = src_s & ~src_q;

  // Edge history and pending bit; in edge mode a new event beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src_s;
      if (!en) begin
        pend <= 1'b0;
      end else if (mode) begin
        if (rise)     pend <= 1'b1;
        else if (clr) pend <= 1'b0;
      end else begin
        pend <= src_q;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: eight source cells, fixed-priority arbitration and
// the IDLE/REQ/SERVICE handshake FSM. Define INT_CTRL_SYNC_EN to synchronize src.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [VEC_W-1:0] RST_VEC = 3'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [15:0]        confINT,
  input  logic               ack,
  input  logic               eoi,
  input  logic [NUM_SRC-1:0] clr_pend,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  state_t             state_q;
  state_t             state_d;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   vec_d;
  logic [VEC_W-1:0]   win;
  logic               ack_acc;
  logic [NUM_SRC-1:0] pend;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic clr_i;
    assign clr_i = clr_pend[i] | (ack_acc && (vec_q == VEC_W'(i)));

    int_src_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .src  (src[i]),
      .en   (confINT[EN_LSB + i]),
      .mode (confINT[MODE_LSB + i]),
      .clr  (clr_i),
      .pend (pend[i])
    );
  end

  assign win = prio_enc(pend);

  // Next state, next vector and ack acceptance; vector re-arbitrates while in REQ
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          state_d = REQ;
          vec_d   = win;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = SERVICE;
          ack_acc = 1'b1;
        end else if (~|pend) begin
          state_d = IDLE;
          vec_d   = RST_VEC;
        end else begin
          vec_d = win;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
          vec_d   = RST_VEC;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = RST_VEC;
      end
    endcase
  end

  // State and vector registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= RST_VEC;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign vector     = vec_q;
  assign pending    = pend;

endmodule
